// File: rtl/inst_prefetch_queue_pkg.sv
// rtl/inst_prefetch_queue_pkg.sv - shared constants and entry type for the instruction prefetch queue
package inst_prefetch_queue_pkg;

   localparam int INST_W = 32;
   localparam int PC_W   = 32;
   localparam int ENTRY_W = PC_W + INST_W;

   localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;
   localparam logic [PC_W-1:0]   PC_STEP  = 32'd4;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } pq_entry_t;

endpackage

// File: rtl/inst_prefetch_queue_fifo.sv
// rtl/inst_prefetch_queue_fifo.sv - in-order {pc, inst} FIFO; clear wins over push and pop
module prefetch_fifo
   import inst_prefetch_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic [ENTRY_W-1:0]          push_entry,
   input  logic                        pop,
   input  logic                        clear,
   output logic [$clog2(DEPTH):0]      count,
   output logic [ENTRY_W-1:0]          head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Storage needs no reset: count gates every read of it.
   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= push_entry;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_prefetch_queue.sv
// rtl/inst_prefetch_queue.sv - credit-limited instruction prefetch buffer feeding the IF/ID register
module inst_prefetch_queue
   import inst_prefetch_queue_pkg::*;
#(
   parameter int               DEPTH    = 4,
   parameter logic [PC_W-1:0]  RESET_PC = 32'h0
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     imem_req,
   output logic [PC_W-1:0]          imem_addr,
   input  logic                     imem_gnt,
   input  logic                     imem_rvalid,
   input  logic [INST_W-1:0]        imem_rdata,
   input  logic                     redirect,
   input  logic [PC_W-1:0]          redirect_pc,
   input  logic                     halt,
   input  logic                     inst_ready,
   output logic                     inst_valid,
   output logic [INST_W-1:0]        inst,
   output logic [PC_W-1:0]          inst_pc,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [PC_W-1:0]    fetch_pc;
   logic [PC_W-1:0]    resp_pc;
   logic [CNT_W-1:0]   outstanding;
   logic [CNT_W-1:0]   discard;
   logic [CNT_W:0]     credit_sum;
   logic               gnt_fire;
   logic               rsp;
   logic               drop;
   logic               push;
   logic               pop;
   pq_entry_t          push_entry;
   pq_entry_t          head;
   logic [ENTRY_W-1:0] head_bits;

   // Queue slots plus in-flight requests never exceed DEPTH, so a response always has room.
   assign credit_sum = {1'b0, occupancy} + {1'b0, outstanding};
   assign imem_req   = !rst && !halt && !redirect && (credit_sum < (CNT_W+1)'(DEPTH));
   assign imem_addr  = fetch_pc;
   assign gnt_fire   = imem_req && imem_gnt;

   // A response with nothing outstanding is a memory-side protocol error and is ignored.
   assign rsp  = imem_rvalid && (outstanding != '0);
   assign drop = (discard != '0);
   assign push = rsp && !drop && !redirect;
   assign pop  = inst_ready && inst_valid && !redirect;

   assign push_entry.pc   = resp_pc;
   assign push_entry.inst = imem_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= outstanding + CNT_W'(gnt_fire) - CNT_W'(rsp);
         if (redirect) begin
            fetch_pc <= redirect_pc;
            resp_pc  <= redirect_pc;
            discard  <= outstanding - CNT_W'(rsp);
         end else begin
            if (gnt_fire) fetch_pc <= fetch_pc + PC_STEP;
            if (rsp) begin
               if (drop) discard <= discard - 1'b1;
               else      resp_pc <= resp_pc + PC_STEP;
            end
         end
      end
   end

   prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .clear      (redirect),
      .count      (occupancy),
      .head       (head_bits)
   );

   assign head       = pq_entry_t'(head_bits);
   assign inst_valid = (occupancy != '0);
   assign inst       = inst_valid ? head.inst : NOP_INST;
   assign inst_pc    = inst_valid ? head.pc : '0;

   ap_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
      !(imem_rvalid && outstanding == '0));

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb/tb_inst_prefetch_queue.sv - randomized scoreboard bench for inst_prefetch_queue
module tb_inst_prefetch_queue;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;
   localparam logic [31:0] NOP      = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        inst_ready;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [2:0]  occupancy;

   inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
      .inst_ready(inst_ready), .inst_valid(inst_valid), .inst(inst),
      .inst_pc(inst_pc), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int due; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

   req_t        pending[$];
   exp_t        exp_q[$];
   logic [31:0] model_pc;
   int          cyc;
   int          n_pass;
   int          n_total;

   int gnt_pct, ready_pct, redir_pct, halt_pct, lat_min, lat_max;
   bit halt_force, force_redir, track;
   logic [31:0] force_pc;
   int first_gnt, first_valid;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1357};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
   endtask

   task automatic cycle();
      logic [9:0] r;
      @(negedge clk);
      cyc++;
      imem_gnt = ($urandom_range(0, 99) < gnt_pct);
      if (pending.size() > 0 && pending[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_data(pending[0].addr);
         void'(pending.pop_front());
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      r = 10'($urandom);
      redirect    = force_redir || ($urandom_range(0, 99) < redir_pct);
      redirect_pc = force_redir ? force_pc : {20'h0, r, 2'b00};
      halt        = halt_force || ($urandom_range(0, 99) < halt_pct);
      inst_ready  = ($urandom_range(0, 99) < ready_pct);
      #2;
      if (imem_req && imem_gnt)
         pending.push_back('{addr: imem_addr, due: cyc + $urandom_range(lat_min, lat_max)});
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, {31'h0, inst_valid}, 32'h0);
      chk({tag, "_inst"}, inst, NOP);
      chk({tag, "_pc"}, inst_pc, 32'h0);
      chk({tag, "_occ"}, {29'h0, occupancy}, 32'h0);
      chk({tag, "_req"}, {31'h0, imem_req}, 32'h0);
   endtask

   task automatic idle_inputs();
      imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; redirect = 0;
      redirect_pc = 0; halt = 0; inst_ready = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #3;
      rst = 1'b1;
      idle_inputs();
      #1;
      check_reset_outputs("midrst");
      pending.delete();
      exp_q.delete();
      model_pc = RESET_PC;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Scoreboard monitor: every grant is an expected delivery; redirect restarts the stream.
   always begin
      @(negedge clk);
      #1;
      if (!rst) begin
         logic exp_req;
         exp_req = !halt && !redirect &&
                   ((int'(occupancy) + pending.size() + int'(imem_rvalid)) < DEPTH);
         chk("imem_req", {31'h0, imem_req}, {31'h0, exp_req});
         chk("valid_vs_occ", {31'h0, inst_valid}, {31'h0, occupancy != 0});
         if (!inst_valid) begin
            chk("empty_inst", inst, NOP);
            chk("empty_pc", inst_pc, 32'h0);
         end
         if (track && first_gnt < 0 && imem_req && imem_gnt) first_gnt = cyc;
         if (track && first_valid < 0 && inst_valid) first_valid = cyc;
         if (imem_req && imem_gnt) begin
            chk("fetch_addr", imem_addr, model_pc);
            exp_q.push_back('{pc: model_pc, data: mem_data(model_pc)});
            model_pc = model_pc + 32'd4;
         end
         if (redirect) begin
            exp_q.delete();
            model_pc = redirect_pc;
         end else if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
               chk("pop_unexpected", inst_pc, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("pop_pc", inst_pc, e.pc);
               chk("pop_inst", inst, e.data);
            end
         end
      end
   end

   initial begin
      n_pass = 0; n_total = 0; cyc = 0;
      gnt_pct = 100; ready_pct = 100; redir_pct = 0; halt_pct = 0;
      lat_min = 1; lat_max = 1;
      halt_force = 0; force_redir = 0; force_pc = 0;
      track = 0; first_gnt = -1; first_valid = -1;
      model_pc = RESET_PC;
      rst = 1'b1;
      idle_inputs();
      #1;
      check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      track = 1;
      @(negedge clk);
      rst = 1'b0;

      // 1-cycle memory, always ready: grant-to-visible latency
      for (int i = 0; i < 20 && first_valid < 0; i++) cycle();
      chk("first_latency", 32'(first_valid - first_gnt), 32'd2);
      track = 0;
      repeat (10) cycle();

      // stall: queue fills and requests stop
      ready_pct = 0;
      repeat (10) cycle();
      chk("stall_occ", {29'h0, occupancy}, 32'd4);
      chk("stall_req", {31'h0, imem_req}, 32'h0);
      ready_pct = 100;
      repeat (10) cycle();

      // redirect with late responses in flight
      lat_min = 3; lat_max = 3;
      repeat (6) cycle();
      force_redir = 1; force_pc = 32'h100;
      cycle();
      force_redir = 0;
      repeat (12) cycle();

      // halt drains and blocks fetch
      lat_min = 2; lat_max = 2;
      repeat (3) cycle();
      halt_force = 1;
      repeat (12) cycle();
      chk("halt_occ", {29'h0, occupancy}, 32'h0);
      chk("halt_req", {31'h0, imem_req}, 32'h0);
      halt_force = 0;
      repeat (5) cycle();

      // reset mid-stream with a partly full queue
      lat_min = 1; lat_max = 1; ready_pct = 0;
      for (int i = 0; i < 20 && occupancy < 3; i++) cycle();
      chk("pre_rst_occ", {31'h0, occupancy >= 3}, 32'h1);
      do_reset();
      ready_pct = 100;
      repeat (10) cycle();

      // randomized traffic
      for (int blk = 0; blk < 15; blk++) begin
         gnt_pct   = $urandom_range(30, 100);
         ready_pct = $urandom_range(20, 100);
         redir_pct = $urandom_range(0, 6);
         halt_pct  = $urandom_range(0, 15);
         lat_min   = 1;
         lat_max   = $urandom_range(1, 4);
         repeat (200) cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
- Instruction-side stage directly upstream of the core's IF/ID register.
- Fetches 32-bit instructions from instruction memory over a request/grant/response handshake and buffers them with their PCs in an in-order queue.
- Presents one instruction per cycle to the core, honouring the core's load-use stall.
- Discards buffered and in-flight instructions on a branch redirect.

Parameters:
- DEPTH, 4, queue entries and maximum outstanding memory requests; power of two, at least 2.
- RESET_PC, 32'h0, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address; always equals fetch_pc.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response data valid; responses return in request order.
- imem_rdata  in  32  response instruction.
- redirect  in  1  branch mispredict or flush from the execute stage.
- redirect_pc  in  32  new fetch address; valid with redirect.
- halt  in  1  core has seen a halt opcode; stop issuing new requests.
- inst_ready  in  1  core consumes the head entry (0 while the core stalls).
- inst_valid  out  1  head entry valid.
- inst  out  32  head instruction; 32'h00000013 (NOP) when empty.
- inst_pc  out  32  PC of the head instruction; 0 when empty.
- occupancy  out  $clog2(DEPTH)+1  number of valid queue entries.

Behaviour:
Internal state:
- fetch_pc: next address to request.
- resp_pc: PC of the next response.
- outstanding: granted requests not yet returned.
- discard: stale responses still to be dropped.
- FIFO of {pc, inst} entries.

Reset (asynchronous):
- fetch_pc = resp_pc = RESET_PC; outstanding = discard = 0; queue empty.
- Outputs: inst_valid = 0, inst = NOP, inst_pc = 0, occupancy = 0.
- imem_req = 0 while rst is high.
- Asserting rst mid-operation abandons everything. Responses that arrive after reset release are counted as valid, so the memory side must be reset together with this block.

Request issue (combinational):
- imem_req = !rst && !halt && !redirect && (occupancy + outstanding < DEPTH).
- Handshake completes when imem_req && imem_gnt: fetch_pc += 4 (wraps modulo 2^32) and outstanding += 1.
- While imem_gnt is low, imem_req stays high and imem_addr stays stable unless redirect or halt intervenes.

Response:
- Each imem_rvalid decrements outstanding.
- If discard > 0: decrement discard and drop the data.
- Otherwise: push {resp_pc, imem_rdata}, then resp_pc += 4.
- Overflow is impossible by the credit rule. imem_rvalid with outstanding == 0 is a protocol error; assert it in simulation and ignore it in RTL.

Pop:
- Occurs when inst_ready && inst_valid.
- Push and pop in the same cycle are both allowed, at any occupancy.
- Latency: grant in cycle t, rvalid at t+1 at the earliest, instruction visible on inst at t+2.
- There is no bypass from imem_rdata to inst.

Redirect (highest priority):
- On the next edge: queue emptied, fetch_pc = resp_pc = redirect_pc.
- discard = outstanding plus any request granted this cycle, minus any response arriving this cycle. Because imem_req is low during redirect, no request is granted in that cycle.
- A response arriving in the redirect cycle is dropped.
- A pop in the redirect cycle is ignored.

Halt:
- Only blocks new requests.
- Outstanding responses are still queued and inst continues to drain.
- Releasing halt resumes fetch at fetch_pc.

Decomposition:
- Shared package: NOP_INST = 32'h00000013, INST_W = 32, PC_W = 32, PC_STEP = 4.
- Sub-module: prefetch_fifo, a synchronous FIFO of {pc, inst} with DEPTH entries.
  - Ports: push, pop, clear, count, head.
  - Clear has priority over push and pop.
  - The FIFO uses the same asynchronous reset.

Test Plan:
- Reset then 1-cycle memory (gnt = 1, rvalid one cycle after grant), inst_ready = 1 -> imem_addr 0, 4, 8...; first inst_valid 2 cycles after the first grant with inst_pc = 0; one instruction per cycle thereafter.
- inst_ready = 0 for 10 cycles, DEPTH = 4 -> occupancy reaches 4 and imem_req drops; on release, inst_pc continues 0, 4, 8, 12 with no gaps or duplicates.
- Memory latency of 3 cycles, 2 requests outstanding, redirect with redirect_pc = 0x100 -> both late responses dropped; next inst_valid shows inst_pc = 0x100 and the data from address 0x100.
- imem_rvalid in the same cycle as redirect -> that data is never presented; discard ends at outstanding − 1.
- halt asserted with 1 request outstanding -> its response is queued and drained; no further imem_req; occupancy reaches 0.
- rst asserted mid-stream with occupancy 3 -> inst_valid = 0, inst = NOP immediately; after release the first imem_addr is RESET_PC.
